rom_port_arbiter: RTL

- Shares the single-port program ROM (synchronous read, 1-cycle latency, word-addressed via address[31:2]) between the RISC-V instruction-fetch port and the data-load port.
- Arbitrates per cycle with round-robin on contention and rejects illegal accesses without touching the ROM.
- Returns read data to the correct requester one cycle after grant.
- Sits between the core's fetch/load units and the ROM instance.

---
 rtl/rom_port_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// Shares one single-port synchronous program ROM between the instruction-fetch and data-load ports.
// Round-robin on contention. Illegal accesses get an error response and never reach the ROM.
module rom_port_arbiter #(
    parameter int LEN       = 10000,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 iReq,
    input  logic [31:0]          iAddress,
    output logic                 iGrant,
    output logic                 iValid,
    output logic [31:0]          iData,
    output logic                 iError,
    input  logic                 dReq,
    input  logic [31:0]          dAddress,
    input  logic                 dWrite,
    output logic                 dGrant,
    output logic                 dValid,
    output logic [31:0]          dData,
    output logic                 dError,
    output logic                 romEnable,
    output logic [31:0]          romAddress,
    output logic [31:0]          romDataIn,
    output logic                 romWriteEnable,
    input  logic [31:0]          romDataOut,
    output logic [CNT_WIDTH-1:0] conflictCount
);

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } port_t;

    localparam logic [29:0] LEN_WORDS = 30'(LEN);

    port_t       last_port;
    port_t       grant_port;
    port_t       resp_port;
    logic        any_grant;
    logic        contention;
    logic        illegal;
    logic [31:0] sel_address;
    logic        resp_valid;
    logic        resp_err;

    // On contention the port that was not served last wins; a lone request is always served.
    always_comb begin
        contention = iReq && dReq;
        any_grant  = iReq || dReq;
        if (contention) begin
            grant_port = (last_port == INST) ? DATA : INST;
        end else if (dReq) begin
            grant_port = DATA;
        end else begin
            grant_port = INST;
        end
        iGrant      = any_grant && (grant_port == INST);
        dGrant      = any_grant && (grant_port == DATA);
        sel_address = (grant_port == DATA) ? dAddress : iAddress;
        illegal     = (sel_address[1:0] != 2'b00)
                   || (sel_address[31:2] >= LEN_WORDS)
                   || ((grant_port == DATA) && dWrite);
        romEnable   = any_grant && !illegal;
        romAddress  = romEnable ? sel_address : 32'h0000_0000;
    end

    assign romDataIn      = 32'h0000_0000;
    assign romWriteEnable = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_port <= INST;
        end else if (any_grant) begin
            last_port <= grant_port;
        end
    end

    // Response tags line up with the ROM's one-cycle read latency, so romDataOut is consumed directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_port  <= INST;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= any_grant;
            if (any_grant) begin
                resp_port <= grant_port;
                resp_err  <= illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflictCount <= '0;
        end else if (contention && (conflictCount != '1)) begin
            conflictCount <= conflictCount + 1'b1;
        end
    end

    assign iValid = resp_valid && (resp_port == INST);
    assign dValid = resp_valid && (resp_port == DATA);
    assign iData  = (iValid && !resp_err) ? romDataOut : 32'h0000_0000;
    assign dData  = (dValid && !resp_err) ? romDataOut : 32'h0000_0000;
    assign iError = iValid && resp_err;
    assign dError = dValid && resp_err;

endmodule
